// File: rtl/fpu_realt_stim_gen.sv
// Operand-vector stimulus generator for the FPU regression bench.
// A 32-bit Galois LFSR feeds N_ARG sanitized real_t operands per vector,
// presented over valid/ready; every eighth vector carries a signed zero in
// slot 0 so both datapaths see the zero corner regularly.

package fpu_pack;
  typedef struct packed {
    logic        sign;
    logic [7:0]  expn;
    logic [22:0] frac;
  } real_t;
endpackage

module fpu_realt_stim_gen
  import fpu_pack::*;
#(
  parameter int          N_ARG = 2,
  parameter int          N_VEC = 256,
  parameter logic [31:0] SEED  = 32'hACE1_2345
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_start,
  input  logic                    i_ready,
  output logic                    o_valid,
  output real_t [N_ARG-1:0]       o_arg,
  output logic [15:0]             o_idx,
  output logic                    o_busy,
  output logic                    o_done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_GEN  = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [2:0]  K_LAST   = 3'(N_ARG - 1);
  localparam logic [15:0] IDX_LAST = 16'(N_VEC - 1);

  logic [1:0]        state_q, state_d;
  logic [31:0]       lfsr_q, lfsr_d;
  logic [31:0]       lfsr_nxt;
  logic [2:0]        k_q, k_d;
  logic [15:0]       idx_q, idx_d;
  real_t [N_ARG-1:0] arg_q, arg_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  real_t             slot;

  // Right-shifting Galois step with taps 32'hA300_0000 (maximal length).
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    logic [31:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ 32'hA300_0000;
    return r;
  endfunction

  // Force a raw word to a finite, normal-or-zero value: Inf/NaN exponents
  // are pulled down to the largest finite one, denormals flush to zero.
  function automatic real_t sanitize(input logic [31:0] w);
    real_t r;
    r = real_t'(w);
    if (r.expn == 8'hFF) r.expn = 8'hFE;
    if (r.expn == 8'h00) r.frac = 23'h0;
    return r;
  endfunction

  // Zero magnitude with the sign kept, for the periodic signed-zero corner.
  function automatic real_t signed_zero(input real_t v);
    real_t r;
    r      = '0;
    r.sign = v.sign;
    return r;
  endfunction

  assign lfsr_nxt = lfsr_step(lfsr_q);

  // Operand for the current GEN slot, with the corner override in slot 0.
  always_comb begin
    slot = sanitize(lfsr_nxt);
    if (k_q == 3'd0 && idx_q[2:0] == 3'b111) slot = signed_zero(slot);
  end

  // Next-state logic for the FSM, LFSR, counters and output registers.
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    k_d     = k_q;
    idx_d   = idx_q;
    arg_d   = arg_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = done_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          lfsr_d  = SEED_EFF;
          k_d     = 3'd0;
          idx_d   = 16'd0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          state_d = S_GEN;
        end
      end
      S_GEN: begin
        lfsr_d = lfsr_nxt;
        for (int j = 0; j < N_ARG; j++) begin
          if (k_q == 3'(j)) arg_d[j] = slot;
        end
        if (k_q == K_LAST) begin
          k_d     = 3'd0;
          valid_d = 1'b1;
          state_d = S_SEND;
        end else begin
          k_d = k_q + 3'd1;
        end
      end
      S_SEND: begin
        if (i_ready) begin
          valid_d = 1'b0;
          if (idx_q == IDX_LAST) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 16'd1;
            state_d = S_GEN;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset drops any vector in flight and clears outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      lfsr_q  <= SEED_EFF;
      k_q     <= 3'd0;
      idx_q   <= 16'd0;
      arg_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      k_q     <= k_d;
      idx_q   <= idx_d;
      arg_q   <= arg_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign o_valid = valid_q;
  assign o_arg   = arg_q;
  assign o_idx   = idx_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;

endmodule

// File: doc/fpu_realt_stim_gen.md
# fpu_realt_stim_gen

Stimulus generator for the FPU regression bench: produces a bounded stream of pseudo-random `real_t` operand vectors and delivers them over a valid/ready handshake. The same vector feeds the RTL unit and the simulation model. Their results go to the `real_t` result checker. Operands are sanitized to finite, normal-or-zero values, and signed-zero corner vectors are injected periodically, so that any mismatch reported downstream reflects the datapath, not special-value handling.

## Interface
- `N_ARG`, 2, operands per vector (1..8)
- `N_VEC`, 256, vectors per run (1..65535)
- `SEED`, 32'hACE1_2345, LFSR seed loaded on every start; a value of 0 is replaced by 32'h1
- `clk`  in  1  clock; single clock domain
- `rst_n`  in  1  reset, synchronous, active-low
- `i_start`  in  1  one-cycle pulse; begins a run from IDLE or DONE
- `i_ready`  in  1  consumer accepts the vector presented this cycle
- `o_valid`  out  1  `o_arg`/`o_idx` hold a vector
- `o_arg`  out  `real_t [N_ARG-1:0]`  operand vector; `real_t` comes from fpu_pack as {sign 1b, expn 8b, frac 23b}, 32 bits
- `o_idx`  out  16  index of the presented vector, 0..N_VEC-1
- `o_busy`  out  1  high in GEN and SEND
- `o_done`  out  1  high in DONE, until the next accepted start or reset

## Operation
- 32-bit Galois LFSR, shifting right:
  - each step computes `lsb = s[0]`, then `s = s >> 1`, then `if (lsb) s ^= 32'hA300_0000`.
  - This is maximal length.
- FSM states: IDLE, GEN, SEND, DONE.
- **IDLE / DONE**, when `i_start` is high:
  - LFSR is loaded with SEED;
  - vector counter and arg counter are cleared;
  - FSM moves to GEN.
  - `i_start` is ignored in GEN and SEND.
- **GEN**: lasts N_ARG cycles, one operand per cycle, k = 0..N_ARG-1.
  - Each cycle the LFSR steps once.
  - The next-state value is sanitized and captured into `o_arg[k]`.
  - After k = N_ARG-1 the FSM moves to SEND.
- **Sanitize**, applied to raw word w:
  - If `expn == 8'hFF`, set `expn = 8'hFE`; frac is kept (no Inf/NaN).
  - If `expn == 0`, set `frac = 0` (no denormals).
  - sign passes through unchanged.
- **Corner injection**: when `o_idx[2:0] == 3'b111`, `o_arg[0]` becomes {sanitized sign, 8'h00, 23'h0}, i.e. a signed zero.
  - The LFSR still steps for that slot.
- **SEND**: `o_valid` is high.
  - On `o_valid && i_ready`, if `o_idx == N_VEC-1` the FSM moves to DONE.
  - Otherwise `o_idx` increments and the FSM moves to GEN.
- Reset, from any state:
  - FSM goes to IDLE;
  - LFSR is set to SEED (or 1 if SEED is 0);
  - all outputs are cleared.
  - A vector in flight is dropped; no partial handshake is completed.

## Timing
- Reset values:
  - `o_valid` = 0, `o_busy` = 0, `o_done` = 0;
  - `o_idx` = 0;
  - `o_arg` = all zeros.
- Start to first `o_valid`: exactly N_ARG+1 cycles.
  - Start sampled at edge 0, GEN occupies edges 1..N_ARG, and `o_valid` is visible after edge N_ARG.
- Minimum throughput: one vector per N_ARG+1 cycles when `i_ready` is held high.
- While `o_valid && !i_ready`, `o_arg` and `o_idx` are stable and `o_valid` stays high.
- `o_valid` drops in the cycle after acceptance; vectors are never presented back-to-back.
- `o_done` rises one cycle after the final handshake.
  - `o_busy` falls in the same cycle.
- All outputs are registered; there are no combinational paths from `i_ready` or `i_start` to any output.
- The run produces N_VEC accepted vectors exactly; `o_idx` never reaches N_VEC.

## Test plan
- **First vectors**: SEED=1, N_ARG=2, `i_start` pulse, `i_ready`=1.
  - `o_valid` rises 3 cycles after start.
  - `o_arg[0]` = 32'hA300_0000 (sign 1, expn 8'h46, frac 0).
  - `o_arg[1]` = 32'h5180_0000.
  - `o_idx` = 0.
- **Inf/NaN sanitize**: SEED=32'hFF00_000A, N_ARG=1.
  - Raw word is 32'h7F80_0005.
  - `o_arg[0]` must be 32'h7F00_0005.
- **Denormal sanitize**: SEED=32'h0000_00A4.
  - Raw word is 32'h0000_0052.
  - `o_arg[0]` must be 32'h0000_0000.
- **Back-pressure**: hold `i_ready`=0 for 10 cycles in SEND.
  - `o_valid`, `o_arg` and `o_idx` stay constant.
  - Then release `i_ready` for 1 cycle: exactly one acceptance, and `o_idx` advances by 1 on the next presentation.
- **Full run with corners**: N_VEC=16, `i_ready` randomized.
  - Exactly 16 handshakes with `o_idx` 0..15 in order.
  - `o_arg[0]` has expn=0 and frac=0 at idx 7 and 15.
  - `o_done`=1 after the last handshake.
  - A start pulse mid-run is ignored; a start in DONE reproduces an identical sequence.
- **Reset mid-operation**: deassert `rst_n` for 1 cycle while in SEND with `o_valid`=1.
  - All outputs read 0 the next cycle and the FSM is in IDLE.
  - A new start reproduces the SEED sequence from idx 0.
